// File: rtl/fermat_inv_ctrl.sv
`default_nettype none
// ============================================================================
// fermat_inv_ctrl : modular inverse a^(p-2) mod p over a shared multiplier
// Revision 1.0
// ============================================================================
module fermat_inv_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             mul_req,
    output logic [WIDTH-1:0] mul_x,
    output logic [WIDTH-1:0] mul_y,
    output logic [WIDTH-1:0] mul_p,
    input  logic             mul_ack,
    input  logic [WIDTH-1:0] mul_z
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_SQR   = 3'd2;
    localparam logic [2:0] S_MUL   = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [IW-1:0]    i_q, i_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             gap_q, gap_d;
    logic             w_req;
    logic             w_ack;

    // gap_q forces one request-free cycle after every acknowledged transaction
    assign w_req = ((state_q == S_SQR) || (state_q == S_MUL)) && !gap_q;
    assign w_ack = w_req && mul_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            p_q      <= '0;
            e_q      <= '0;
            acc_q    <= '0;
            i_q      <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            gap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            p_q      <= p_d;
            e_q      <= e_d;
            acc_q    <= acc_d;
            i_q      <= i_d;
            err_q    <= err_d;
            result_q <= result_d;
            gap_q    <= gap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        p_d      = p_q;
        e_d      = e_q;
        acc_d    = acc_q;
        i_d      = i_q;
        err_d    = err_q;
        result_d = result_q;
        gap_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    p_d     = p;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((p_q < WIDTH'(3)) || !p_q[0] || (a_q == '0) || (a_q >= p_q)) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = S_FIN;
                end else begin
                    e_d     = p_q - WIDTH'(2);
                    acc_d   = WIDTH'(1);
                    i_d     = IW'(WIDTH - 1);
                    state_d = S_SQR;
                end
            end
            S_SQR: begin
                if (w_ack) begin
                    acc_d = mul_z;
                    gap_d = 1'b1;
                    if (e_q[i_q]) begin
                        state_d = S_MUL;
                    end else if (i_q != '0) begin
                        i_d = i_q - IW'(1);
                    end else begin
                        result_d = mul_z;
                        state_d  = S_FIN;
                    end
                end
            end
            S_MUL: begin
                if (w_ack) begin
                    acc_d = mul_z;
                    gap_d = 1'b1;
                    if (i_q != '0) begin
                        i_d     = i_q - IW'(1);
                        state_d = S_SQR;
                    end else begin
                        result_d = mul_z;
                        state_d  = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_FIN);
        err     = err_q;
        result  = result_q;
        mul_req = w_req;
        mul_x   = '0;
        mul_y   = '0;
        mul_p   = '0;
        if (state_q == S_SQR) begin
            mul_x = acc_q;
            mul_y = acc_q;
            mul_p = p_q;
        end else if (state_q == S_MUL) begin
            mul_x = acc_q;
            mul_y = a_q;
            mul_p = p_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fermat_inv_ctrl.sv
`default_nettype none
// Scoreboard bench for fermat_inv_ctrl with a random-latency multiplier model.
module tb_fermat_inv_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] p = '0;
    logic         busy, done, err, mul_req;
    logic [W-1:0] result, mul_x, mul_y, mul_p;
    logic         mul_ack = 1'b0;
    logic [W-1:0] mul_z = '0;

    fermat_inv_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .p       (p),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result),
        .mul_req (mul_req),
        .mul_x   (mul_x),
        .mul_y   (mul_y),
        .mul_p   (mul_p),
        .mul_ack (mul_ack),
        .mul_z   (mul_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           ntx;
        int           scyc;
        bit           chk_lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ntx_cur = 0;
    bit   inject_stray = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic e, input int n, input bit lat);
        exp_t x;
        x.res = r; x.err = e; x.ntx = n; x.scyc = 0; x.chk_lat = lat;
        return x;
    endfunction

    // Reference: invalidity rules, repeated multiplication for a^(p-2), and
    // transaction count = one square per exponent bit plus one multiply per set bit.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mp);
        exp_t r;
        longint unsigned acc;
        int unsigned e;
        r.scyc = 0;
        if (mp < 3 || mp % 2 == 0 || ma == 0 || ma >= mp) begin
            r.res = '0; r.err = 1'b1; r.ntx = 0; r.chk_lat = 1'b1;
        end else begin
            acc = 1;
            e = int'(mp) - 2;
            for (int unsigned k = 0; k < e; k++) acc = (acc * ma) % mp;
            r.res = W'(acc); r.err = 1'b0; r.chk_lat = 1'b0;
            r.ntx = W;
            for (int b = 0; b < W; b++) if (((e >> b) & 1) == 1) r.ntx++;
        end
        return r;
    endfunction

    // Shared multiplier: random 1-10 cycle latency, single-cycle ack.
    initial begin
        bit           active;
        bit           prev_ack;
        int           lat;
        logic [W-1:0] cx, cy, cp;
        active = 1'b0; prev_ack = 1'b0; lat = 0;
        cx = '0; cy = '0; cp = '0;
        forever begin
            @(negedge clk);
            if (prev_ack) chk("req_gap_after_ack", mul_req, 0);
            prev_ack = 1'b0;
            mul_ack  = 1'b0;
            if (!mul_req) begin
                active = 1'b0;
                if (inject_stray) begin
                    mul_ack = 1'b1;
                    mul_z = W'($urandom);
                    inject_stray = 1'b0;
                end
            end else begin
                if (!active) begin
                    active = 1'b1;
                    lat = $urandom_range(1, 10);
                    cx = mul_x; cy = mul_y; cp = mul_p;
                end else begin
                    chk("operands_stable", {mul_x, mul_y, mul_p}, {cx, cy, cp});
                end
                lat--;
                if (lat == 0) begin
                    mul_z = W'((64'(cx) * 64'(cy)) % 64'(cp));
                    mul_ack = 1'b1;
                    prev_ack = 1'b1;
                    active = 1'b0;
                    ntx_cur++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual_result=%0d expected=no_done", result);
                end else begin
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("err", err, e.err);
                    chk("mul_transactions", ntx_cur, e.ntx);
                    if (e.chk_lat) chk("done_latency", cyc - e.scyc, 2);
                end
                ntx_cur = 0;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ip, input exp_t e);
        wait_idle();
        a = ia; p = ip; start = 1'b1;
        e.scyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        p = W'($urandom);
        chk("busy_after_start", busy, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int unsigned primes[8] = '{3, 5, 7, 11, 13, 257, 4099, 65521};

    initial begin
        logic [W-1:0] ra, rp;
        int           n;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_result", result, 0);
        chk("reset_mul_req", mul_req, 0);
        chk("reset_mul_ops", {mul_x, mul_y, mul_p}, 0);
        reset = 1'b1;
        @(negedge clk);

        issue(16'd3, 16'd11, mk(16'd4, 1'b0, 18, 1'b0));
        issue(16'd2, 16'd13, mk(16'd7, 1'b0, 19, 1'b0));
        issue(16'd16, 16'd17, mk(16'd16, 1'b0, 20, 1'b0));

        issue(16'd0, 16'd11, mk(16'd0, 1'b1, 0, 1'b1));
        issue(16'd3, 16'd10, mk(16'd0, 1'b1, 0, 1'b1));
        issue(16'd7, 16'd7, mk(16'd0, 1'b1, 0, 1'b1));
        issue(16'd1, 16'd2, mk(16'd0, 1'b1, 0, 1'b1));

        // A second start while busy must not be taken.
        issue(16'd5, 16'd13, mk(16'd8, 1'b0, 19, 1'b0));
        repeat (4) @(negedge clk);
        a = 16'd9; p = 16'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("result_held_after_ignored_start", result, 8);

        // Reset asserted during a pending squaring.
        a = 16'd3; p = 16'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!mul_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mul_req_seen_before_reset", mul_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_mul_req", mul_req, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_result", result, 0);
        @(negedge clk);
        reset = 1'b1;
        ntx_cur = 0;
        inject_stray = 1'b1;
        repeat (3) @(negedge clk);
        chk("stray_ack_busy", busy, 0);
        chk("stray_ack_mul_req", mul_req, 0);
        issue(16'd2, 16'd13, mk(16'd7, 1'b0, 19, 1'b0));

        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                rp = W'($urandom);
                ra = W'($urandom);
            end else begin
                rp = W'(primes[$urandom_range(0, 7)]);
                ra = W'($urandom_range(1, int'(rp) - 1));
            end
            issue(ra, rp, model(ra, rp));
        end

        n = 0;
        while ((sb.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
